// File: rtl/mem_pkg.sv
// Shared memory-subsystem geometry and the L1 fill controller state encoding.
// Both l1_fill_ctrl and l1_cache_dm import these so their line layout always agrees.
package mem_pkg;

    localparam int LINE_SIZE      = 16;
    localparam int WORD_BYTES     = 4;
    localparam int WORDS_PER_LINE = LINE_SIZE / WORD_BYTES;
    localparam int OFFSET_BITS    = $clog2(LINE_SIZE);
    localparam int BEAT_BITS      = $clog2(WORDS_PER_LINE);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } fill_state_t;

endpackage

// File: rtl/l1_fill_ctrl.sv
// Read-miss line fill and write-through forwarding between the CPU memory stage,
// a direct-mapped L1 and main memory. The current FSM state is exported on state_dbg.
module l1_fill_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = mem_pkg::LINE_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_valid,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_w_data,
    input  logic                  cache_hit,
    output logic                  cpu_stall,
    output logic                  fill_en,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  fill_mark_valid,
    output logic                  mreq_valid,
    input  logic                  mreq_ready,
    output logic                  mreq_we,
    output logic [ADDR_WIDTH-1:0] mreq_addr,
    output logic [DATA_WIDTH-1:0] mreq_wdata,
    input  logic                  mresp_valid,
    input  logic [DATA_WIDTH-1:0] mresp_data,
    output fill_state_t           state_dbg
);

    // Handshake: a main-memory request transfers on a cycle with mreq_valid & mreq_ready;
    // while valid is high and ready is low every request field holds its value.
    // mresp_valid carries one read word and is only consumed in RD_WAIT.

    localparam int WORD_BYTES_L = DATA_WIDTH / 8;
    localparam int WORD_BITS    = $clog2(WORD_BYTES_L);
    localparam int OFF_BITS     = $clog2(LINE_SIZE);
    localparam int N_BEATS      = LINE_SIZE / WORD_BYTES_L;
    localparam int BEAT_W       = $clog2(N_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

    fill_state_t           state_q;
    fill_state_t           state_d;
    logic [BEAT_W-1:0]     beat_q;
    logic [ADDR_WIDTH-1:0] line_base_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    logic                  read_miss;
    logic                  write_req;
    logic                  last_beat;
    logic                  resp_fire;
    logic [ADDR_WIDTH-1:0] beat_addr;

    assign read_miss = mem_valid & ~mem_we & ~cache_hit;
    assign write_req = mem_valid & mem_we;
    assign last_beat = (beat_q == LAST_BEAT);
    assign resp_fire = (state_q == RD_WAIT) & mresp_valid;
    assign beat_addr = line_base_q | (ADDR_WIDTH'(beat_q) << WORD_BITS);
    assign state_dbg = state_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (write_req) begin
                    state_d = WR_REQ;
                end else if (read_miss) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                if (mreq_ready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mresp_valid) begin
                    state_d = last_beat ? DONE : RD_REQ;
                end
            end
            WR_REQ: begin
                if (mreq_ready) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode; fill outputs follow mresp_valid combinationally in RD_WAIT
    always_comb begin
        cpu_stall       = 1'b0;
        fill_en         = 1'b0;
        fill_addr       = '0;
        fill_data       = '0;
        fill_mark_valid = 1'b0;
        mreq_valid      = 1'b0;
        mreq_we         = 1'b0;
        mreq_addr       = '0;
        mreq_wdata      = '0;
        case (state_q)
            IDLE: begin
                cpu_stall = read_miss | write_req;
            end
            RD_REQ: begin
                cpu_stall  = 1'b1;
                mreq_valid = 1'b1;
                mreq_addr  = beat_addr;
            end
            RD_WAIT: begin
                cpu_stall = 1'b1;
                if (mresp_valid) begin
                    fill_en         = 1'b1;
                    fill_addr       = beat_addr;
                    fill_data       = mresp_data;
                    fill_mark_valid = last_beat;
                end
            end
            WR_REQ: begin
                cpu_stall  = 1'b1;
                mreq_valid = 1'b1;
                mreq_we    = 1'b1;
                mreq_addr  = wr_addr_q;
                mreq_wdata = wr_data_q;
            end
            default: begin
                cpu_stall = 1'b0;
            end
        endcase
    end

    // Beat counter and request latches; beat stops at the last word instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q      <= '0;
            line_base_q <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            if ((state_q == IDLE) && read_miss) begin
                line_base_q <= {mem_addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
                beat_q      <= '0;
            end
            if ((state_q == IDLE) && write_req) begin
                wr_addr_q <= mem_addr;
                wr_data_q <= mem_w_data;
            end
            if (resp_fire && !last_beat) begin
                beat_q <= beat_q + BEAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_l1_fill_ctrl.sv
// Bench for l1_fill_ctrl: behavioural L1 and main memory around the DUT, a vector
// table of CPU accesses, plus reset-mid-fill and stray-response sequences.
module tb_l1_fill_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_w_data = '0;
  logic        cache_hit = 1'b0;
  logic        cpu_stall;
  logic        fill_en;
  logic [31:0] fill_addr;
  logic [31:0] fill_data;
  logic        fill_mark_valid;
  logic        mreq_valid;
  logic        mreq_ready = 1'b0;
  logic        mreq_we;
  logic [31:0] mreq_addr;
  logic [31:0] mreq_wdata;
  logic        mresp_valid = 1'b0;
  logic [31:0] mresp_data = '0;
  fill_state_t state_dbg;

  l1_fill_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LINE_SIZE(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
    .cache_hit(cache_hit), .cpu_stall(cpu_stall),
    .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data),
    .fill_mark_valid(fill_mark_valid),
    .mreq_valid(mreq_valid), .mreq_ready(mreq_ready), .mreq_we(mreq_we),
    .mreq_addr(mreq_addr), .mreq_wdata(mreq_wdata),
    .mresp_valid(mresp_valid), .mresp_data(mresp_data),
    .state_dbg(state_dbg)
  );

  // clock/reset
  always #5 clk = ~clk;

  // scoreboard queues: requests {we,addr,wdata}, fills {mark,addr,data}
  logic [64:0] exp_req_q[$];
  logic [64:0] exp_fill_q[$];
  int total = 0;
  int bad = 0;

  // behavioural direct-mapped L1: 16 lines, index addr[7:4]
  logic [23:0] c_tag [16] = '{default: 24'h0};
  logic        c_valid [16] = '{default: 1'b0};
  logic [31:0] c_data [16][4] = '{default: '{default: 32'h0}};

  logic [31:0] mainmem [logic [31:0]];
  logic [31:0] gold [logic [31:0]];

  int          ready_low_left = 0;
  int          resp_left = -1;
  int          rlat_cur = 0;
  logic [31:0] resp_addr = '0;
  bit          stray_mode = 0;
  bit          req_held = 0;
  logic [64:0] held_req = '0;
  logic        last_stall = 1'b0;

  function automatic logic model_hit(input logic [31:0] a);
    return c_valid[a[7:4]] && (c_tag[a[7:4]] == a[31:8]);
  endfunction

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    if (a[31:4] == 28'h0000123) return 32'hA0 + {30'b0, a[3:2]};
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mainmem.exists(a)) return mainmem[a];
    return mem_init(a);
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    if (gold.exists(a)) return gold[a];
    return mem_init(a);
  endfunction

  // the L1 itself: fills from the controller, store hits update in place on retire
  always @(posedge clk) begin
    if (fill_en) begin
      c_data[fill_addr[7:4]][fill_addr[3:2]] <= fill_data;
      if (fill_mark_valid) begin
        c_valid[fill_addr[7:4]] <= 1'b1;
        c_tag[fill_addr[7:4]]   <= fill_addr[31:8];
      end else begin
        c_valid[fill_addr[7:4]] <= 1'b0;
      end
    end else if (mem_valid && mem_we && !cpu_stall && model_hit(mem_addr)) begin
      c_data[mem_addr[7:4]][mem_addr[3:2]] <= mem_w_data;
    end
  end

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [64:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h expected nothing (t=%0t)", name, act, $time);
  endtask

  // sample DUT outputs on the falling edge and feed the scoreboard / memory model
  task automatic sample_phase();
    logic [64:0] e;
    @(negedge clk);
    if (mreq_valid) begin
      if (req_held) chk("req_stable", {mreq_we, mreq_addr, mreq_wdata}, held_req);
      if (mreq_ready) begin
        req_held = 0;
        if (exp_req_q.size() == 0) begin
          fail_now("unexpected_req", {mreq_we, mreq_addr, mreq_wdata});
        end else begin
          e = exp_req_q.pop_front();
          chk("req", {mreq_we, mreq_addr, mreq_wdata}, e);
        end
        if (mreq_we) begin
          mainmem[mreq_addr] = mreq_wdata;
        end else begin
          resp_left = rlat_cur;
          resp_addr = mreq_addr;
        end
      end else begin
        if (ready_low_left > 0) ready_low_left--;
        req_held = 1;
        held_req = {mreq_we, mreq_addr, mreq_wdata};
      end
    end else begin
      chk("req_idle_zero", {mreq_we, mreq_addr, mreq_wdata}, 65'h0);
    end
    if (fill_en) begin
      if (exp_fill_q.size() == 0) begin
        fail_now("unexpected_fill", {fill_mark_valid, fill_addr, fill_data});
      end else begin
        e = exp_fill_q.pop_front();
        chk("fill", {fill_mark_valid, fill_addr, fill_data}, e);
      end
    end else begin
      chk("fill_idle_zero", {fill_mark_valid, fill_addr, fill_data}, 65'h0);
    end
    last_stall = cpu_stall;
  endtask

  // drive environment inputs just after the rising edge
  task automatic drive_phase();
    @(posedge clk);
    #1;
    mreq_ready  = (ready_low_left == 0);
    mresp_valid = 1'b0;
    mresp_data  = '0;
    if (resp_left == 0) begin
      mresp_valid = 1'b1;
      mresp_data  = mem_rd(resp_addr);
      resp_left   = -1;
    end else if (resp_left > 0) begin
      resp_left--;
    end else if (stray_mode && (state_dbg == IDLE || state_dbg == RD_REQ)) begin
      mresp_valid = 1'b1;
      mresp_data  = 32'hBAD0_0000 | $urandom_range(0, 255);
    end
    cache_hit = mem_valid && model_hit(mem_addr);
  endtask

  // one CPU access: push expectations, run to completion, check stall count and data
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int rlow, input int rlat, input int exp_stall);
    logic        hit;
    logic [31:0] a;
    int          n;
    bit          done;
    hit = model_hit(addr);
    rlat_cur = rlat;
    ready_low_left = rlow;
    if (we) begin
      exp_req_q.push_back({1'b1, addr, wdata});
      gold[addr] = wdata;
    end else if (!hit) begin
      for (int i = 0; i < 4; i++) begin
        a = {addr[31:4], 4'h0} + 32'(i * 4);
        exp_req_q.push_back({1'b0, a, 32'h0});
        exp_fill_q.push_back({(i == 3), a, gold_rd(a)});
      end
    end
    mem_valid  = 1'b1;
    mem_we     = we;
    mem_addr   = addr;
    mem_w_data = wdata;
    mreq_ready = (ready_low_left == 0);
    cache_hit  = model_hit(addr);
    n = 0;
    done = 0;
    for (int c = 0; c < 80 && !done; c++) begin
      sample_phase();
      if (!last_stall) begin
        done = 1;
        if (!we) begin
          chk("rd_hit_at_done", {64'h0, cache_hit}, 65'h1);
          chk("rd_data", {33'h0, c_data[addr[7:4]][addr[3:2]]}, {33'h0, gold_rd(addr)});
        end
      end else begin
        n++;
      end
      drive_phase();
    end
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    cache_hit = 1'b0;
    chk("access_done", {64'h0, done}, 65'h1);
    chk("stall_cycles", 65'(n), 65'(exp_stall));
    chk("req_q_empty", 65'(exp_req_q.size()), 65'h0);
    chk("fill_q_empty", 65'(exp_fill_q.size()), 65'h0);
    exp_req_q.delete();
    exp_fill_q.delete();
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {cpu_stall, fill_en, fill_mark_valid, mreq_valid, mreq_we, 3'(state_dbg)}, 65'h0);
    chk({name, "_addr"}, {1'b0, fill_addr, mreq_addr}, 65'h0);
    chk({name, "_data"}, {1'b0, fill_data, mreq_wdata}, 65'h0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rlow;
    int          rlat;
    bit          stray;
    int          exp_stall;
  } vec_t;

  vec_t vecs[10];

  initial begin : main
    logic [31:0] a;
    logic        we;
    int          rlow;
    int          rlat;
    int          es;
    bit          reached;

    vecs[0] = '{1'b0, 32'h0000_1234, 32'h0,         0, 0, 0, 9};
    vecs[1] = '{1'b0, 32'h0000_1238, 32'h0,         0, 0, 0, 0};
    vecs[2] = '{1'b1, 32'h0000_1230, 32'hDEAD_BEEF, 3, 0, 0, 5};
    vecs[3] = '{1'b0, 32'h0000_1230, 32'h0,         0, 0, 0, 0};
    vecs[4] = '{1'b1, 32'h0000_8000, 32'h1111_2222, 0, 0, 0, 2};
    vecs[5] = '{1'b0, 32'h0000_8000, 32'h0,         0, 0, 0, 9};
    vecs[6] = '{1'b0, 32'h0000_4440, 32'h0,         2, 1, 1, 15};
    vecs[7] = '{1'b0, 32'h0000_444C, 32'h0,         0, 0, 0, 0};
    vecs[8] = '{1'b1, 32'h0000_4448, 32'h0BAD_F00D, 0, 0, 0, 2};
    vecs[9] = '{1'b0, 32'h0000_9010, 32'h0,         0, 2, 0, 17};

    // reset state
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset_outputs");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // stray responses in IDLE
    stray_mode = 1;
    for (int i = 0; i < 3; i++) begin
      sample_phase();
      chk("stray_idle_no_fill", {64'h0, fill_en}, 65'h0);
      chk("stray_idle_state", 65'(state_dbg), 65'(IDLE));
      drive_phase();
    end
    stray_mode = 0;
    sample_phase();
    drive_phase();

    // vector table
    for (int v = 0; v < 10; v++) begin
      stray_mode = vecs[v].stray;
      do_access(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].rlow, vecs[v].rlat,
                vecs[v].exp_stall);
      stray_mode = 0;
    end

    // reset in RD_WAIT at beat 2
    a = 32'h0000_5670;
    rlat_cur = 3;
    ready_low_left = 0;
    for (int i = 0; i < 3; i++) begin
      exp_req_q.push_back({1'b0, a + 32'(i * 4), 32'h0});
      if (i < 2) exp_fill_q.push_back({1'b0, a + 32'(i * 4), gold_rd(a + 32'(i * 4))});
    end
    mem_valid = 1'b1;
    mem_we    = 1'b0;
    mem_addr  = a;
    mreq_ready = 1'b1;
    cache_hit = model_hit(a);
    reached = 0;
    for (int c = 0; c < 60 && !reached; c++) begin
      sample_phase();
      drive_phase();
      if (exp_req_q.size() == 0 && exp_fill_q.size() == 0 && state_dbg == RD_WAIT) reached = 1;
    end
    chk("midfill_reached", {64'h0, reached}, 65'h1);
    rst_n = 1'b0;
    mem_valid = 1'b0;
    cache_hit = 1'b0;
    resp_left = -1;
    req_held = 0;
    #1 chk_all_zero("midfill_reset_outputs");
    sample_phase();
    drive_phase();
    rst_n = 1'b1;
    resp_addr = a + 32'h8;
    resp_left = 0;
    for (int i = 0; i < 3; i++) begin
      drive_phase();
      sample_phase();
      chk("late_resp_no_fill", {64'h0, fill_en}, 65'h0);
      chk("late_resp_state", 65'(state_dbg), 65'(IDLE));
    end
    drive_phase();
    do_access(1'b0, a + 32'h4, 32'h0, 0, 0, 9);

    // random traffic
    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 4))
        0: a = 32'h0000_1230;
        1: a = 32'h0000_2230;
        2: a = 32'h0000_4440;
        3: a = 32'h0000_C0F0;
        default: a = 32'h0000_9010;
      endcase
      a = a | 32'($urandom_range(0, 3) << 2);
      we = ($urandom_range(0, 2) == 0);
      rlow = $urandom_range(0, 2);
      rlat = $urandom_range(0, 2);
      if (we) es = 2 + rlow;
      else if (model_hit(a)) es = 0;
      else es = 9 + rlow + 4 * rlat;
      do_access(we, a, $urandom, rlow, rlat, es);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l1_fill_ctrl.md
# l1_fill_ctrl

Miss and write-through controller between the CPU memory stage, the direct-mapped L1 data cache, and main memory. It watches each CPU access together with the cache's hit flag and stalls the CPU on a read miss or any write. On a read miss it fetches the 16-byte line from main memory one word at a time and drives the cache fill port, marking the line valid on the last word. On a write it forwards the word to main memory: write-through, no write-allocate.

## Interface
Parameters:
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 32, byte address width.
- LINE_SIZE, 16, line size in bytes; this gives WORDS_PER_LINE = 4 and a 2-bit beat counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_valid  in  1  CPU access valid.
- mem_we  in  1  CPU access is a store.
- mem_addr  in  ADDR_WIDTH  CPU byte address, word-aligned.
- mem_w_data  in  DATA_WIDTH  CPU store data.
- cache_hit  in  1  combinational hit flag from the L1.
- cpu_stall  out  1  hold the CPU memory stage.
- fill_en  out  1  fill strobe to the L1.
- fill_addr  out  ADDR_WIDTH  address of the word being filled.
- fill_data  out  DATA_WIDTH  fill word.
- fill_mark_valid  out  1  set tag and valid for the line; high only on the last beat.
- mreq_valid  out  1  main-memory request valid.
- mreq_ready  in  1  main memory accepts the request.
- mreq_we  out  1  request is a write.
- mreq_addr  out  ADDR_WIDTH  request word address.
- mreq_wdata  out  DATA_WIDTH  write data.
- mresp_valid  in  1  read data valid; only one read is outstanding at a time.
- mresp_data  in  DATA_WIDTH  read data.

## Operation
States (FSM): IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.

IDLE
- A read miss (mem_valid & !mem_we & !cache_hit):
  - latch line_base = {mem_addr[ADDR_WIDTH-1:4], 4'b0};
  - clear beat to 0;
  - go to RD_REQ.
- A write (mem_valid & mem_we, hit or miss):
  - latch mem_addr and mem_w_data;
  - go to WR_REQ.
- A read hit or no access: stay in IDLE.

RD_REQ
- Drive mreq_valid=1, mreq_we=0, mreq_addr = line_base | (beat<<2).
- On mreq_ready, go to RD_WAIT.

RD_WAIT
- On mresp_valid:
  - fill_en=1, fill_addr = line_base | (beat<<2), fill_data = mresp_data;
  - fill_mark_valid=1 when beat==3;
  - if beat==3 go to DONE, otherwise increment beat and go to RD_REQ.

WR_REQ
- Drive mreq_valid=1, mreq_we=1, mreq_addr = latched address, mreq_wdata = latched data.
- On mreq_ready, go to DONE.

DONE
- One cycle, then unconditionally back to IDLE.
- The CPU access completes in this cycle: the read now hits, or the store retires.

Outputs
- cpu_stall = (IDLE & (read miss | write)) | RD_REQ | RD_WAIT | WR_REQ.
- cpu_stall is low in DONE and on IDLE read hits.
- Memory request outputs are registered-state decodes and are 0 outside RD_REQ/WR_REQ.
- Fill outputs are combinational from RD_WAIT & mresp_valid and are 0 otherwise.
- Request outputs stay stable while mreq_valid & !mreq_ready.

Boundary rules
- mresp_valid outside RD_WAIT is ignored and never generates a fill.
- beat is 2 bits; it is never incremented past 3, so it does not wrap.
- On a write hit the L1 updates itself; the controller does not touch the fill port.
- On a write miss no fill occurs.
- Reset in any state, including mid-fill:
  - state=IDLE, beat=0, latches cleared;
  - every output is 0;
  - the partially filled line stays invalid, because fill_mark_valid was never issued;
  - a late mresp_valid after reset is dropped.

## Timing
- Reset value of every output: 0.
- Read hit: zero added cycles; no stall.
- Read miss, with mreq_ready=1 and the response one cycle after acceptance:
  - 2 cycles per beat;
  - cpu_stall is high for 9 cycles (the IDLE detect cycle plus 8 cycles of beats);
  - the DONE cycle (cycle 9) returns the hit data.
- Write, with mreq_ready=1: stall for 2 cycles (IDLE, WR_REQ), then DONE.
- Each extra cycle of mreq_ready low or response latency adds exactly one stall cycle.
- Last fill edge: tag and valid are written on the clock edge leaving RD_WAIT, so cache_hit is 1 during DONE.

## Structure
- Shared package mem_pkg holds:
  - LINE_SIZE, WORDS_PER_LINE, OFFSET_BITS;
  - the fill_state_t enum {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE}.
- l1_cache_dm imports the same geometry constants from mem_pkg.
- Single module: FSM, beat counter and address/data latches. No sub-module is needed.

## Test plan
- Reset mid-fill:
  - stimulus: rst_n low during RD_WAIT at beat 2;
  - required: all outputs 0, state IDLE;
  - a following mresp_valid produces no fill_en;
  - a re-access to the line misses again.
- Read miss at 0x0000_1234, mreq_ready=1, memory returning 0xA0..0xA3:
  - mreq_addr sequence 0x1230, 0x1234, 0x1238, 0x123C;
  - four fill_en pulses, fill_mark_valid only with 0xA3;
  - cpu_stall high for 9 cycles;
  - the DONE cycle reads 0xA1.
- Read hit after that fill: access 0x1238 -> cpu_stall 0, no mreq_valid, data 0xA2.
- Write hit to 0x1230 with 0xDEADBEEF, mreq_ready held low for 3 cycles:
  - request fields stable throughout;
  - cpu_stall high for 5 cycles;
  - memory receives the write;
  - no fill_en.
- Write miss to 0x8000: one memory write, no fill; a subsequent read of 0x8000 misses.
- Stray mresp_valid pulse in IDLE and in RD_REQ -> ignored, with no fill_en and no state change.
